winograd_tile_loader: RTL and testbench

Upstream feeder for the Winograd F(2x2,3x3) convolution engine that drives save_unit. It walks one input activation map stored row-major in SRAM and reads each overlapping 4x4 input tile (stride 2) with pipelined single-word reads. It presents each tile as a 256-bit bundle to the engine through a valid/ready handshake, then pulses done after the last tile.

---
 rtl/winograd_tile_loader.sv | 186 ++++++++++++++++++
 tb/tb_winograd_tile_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/winograd_tile_loader.sv
// Walks a square activation map in SRAM and gathers each overlapping 4x4 tile (stride 2)
// into a 256-bit bundle for the Winograd F(2x2,3x3) engine, handing it over with valid/ready.
module winograd_tile_loader #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int SRAM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           size_act,
    input  logic [ADDR_W-1:0]    address_read_base,
    output logic [ADDR_W-1:0]    address,
    output logic                 enable_sram,
    output logic                 wea_sram,
    input  logic [DATA_W-1:0]    data_in,
    output logic [16*DATA_W-1:0] tile_data,
    output logic                 tile_valid,
    input  logic                 tile_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    localparam int DRAIN_W = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ISSUE, S_DRAIN, S_HOLD, S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [7:0]         n_reg;
    logic [ADDR_W-1:0]  base_reg;
    logic [7:0]         tr_reg, tc_reg;
    logic [3:0]         k_reg;
    logic [DRAIN_W-1:0] drain_reg;
    logic               err_reg;

    logic [7:0]  n_m4;
    logic        cfg_bad, last_k, drain_last, last_tile;
    logic [ADDR_W-1:0] row_a, col_a, addr_calc;

    assign n_m4       = n_reg - 8'd4;
    assign cfg_bad    = (n_reg < 8'd4) || n_reg[0];
    assign last_k     = (k_reg == 4'd15);
    assign drain_last = (drain_reg == DRAIN_W'(SRAM_LAT - 1));
    assign last_tile  = (tr_reg == n_m4) && (tc_reg == n_m4);

    // Element address inside the map; wraps modulo 2^ADDR_W by construction.
    assign row_a     = ADDR_W'(tr_reg) + ADDR_W'(k_reg[3:2]);
    assign col_a     = ADDR_W'(tc_reg) + ADDR_W'(k_reg[1:0]);
    assign addr_calc = base_reg + row_a * ADDR_W'(n_reg) + col_a;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_CHECK;
            S_CHECK: state_next = cfg_bad ? S_DONE : S_ISSUE;
            S_ISSUE: if (last_k) state_next = S_DRAIN;
            S_DRAIN: if (drain_last) state_next = S_HOLD;
            S_HOLD:  if (tile_ready) state_next = last_tile ? S_DONE : S_ISSUE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        address     = '0;
        enable_sram = 1'b0;
        wea_sram    = 1'b0;
        tile_valid  = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        cfg_err     = 1'b0;
        case (state_reg)
            S_IDLE:  busy = 1'b0;
            S_ISSUE: begin
                enable_sram = 1'b1;
                address     = addr_calc;
            end
            S_HOLD:  tile_valid = 1'b1;
            S_DONE:  begin
                done    = 1'b1;
                cfg_err = err_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            n_reg     <= '0;
            base_reg  <= '0;
            tr_reg    <= '0;
            tc_reg    <= '0;
            k_reg     <= '0;
            drain_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: if (start) begin
                    n_reg    <= size_act;
                    base_reg <= address_read_base;
                end
                S_CHECK: begin
                    tr_reg  <= '0;
                    tc_reg  <= '0;
                    k_reg   <= '0;
                    err_reg <= cfg_bad;
                end
                S_ISSUE: begin
                    k_reg     <= k_reg + 4'd1;
                    drain_reg <= '0;
                end
                S_DRAIN: drain_reg <= drain_reg + DRAIN_W'(1);
                // Advance row-major over tile corners on each accepted transfer.
                S_HOLD: if (tile_ready) begin
                    k_reg <= '0;
                    if (tc_reg == n_m4) begin
                        tc_reg <= '0;
                        tr_reg <= tr_reg + 8'd2;
                    end else begin
                        tc_reg <= tc_reg + 8'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture line mirrors the SRAM read latency, carrying (valid, slot index).
    logic       pipe_vld_reg [SRAM_LAT];
    logic [3:0] pipe_k_reg   [SRAM_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < SRAM_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst_n) begin
                        pipe_vld_reg[gi] <= 1'b0;
                        pipe_k_reg[gi]   <= '0;
                    end else begin
                        pipe_vld_reg[gi] <= (state_reg == S_ISSUE);
                        pipe_k_reg[gi]   <= k_reg;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst_n) begin
                        pipe_vld_reg[gi] <= 1'b0;
                        pipe_k_reg[gi]   <= '0;
                    end else begin
                        pipe_vld_reg[gi] <= pipe_vld_reg[gi-1];
                        pipe_k_reg[gi]   <= pipe_k_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic [DATA_W-1:0] slot_reg [16];

    generate
        for (gi = 0; gi < 16; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    slot_reg[gi] <= '0;
                end else if (pipe_vld_reg[SRAM_LAT-1] && (pipe_k_reg[SRAM_LAT-1] == 4'(gi))) begin
                    slot_reg[gi] <= data_in;
                end
            end
            assign tile_data[gi*DATA_W +: DATA_W] = slot_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_winograd_tile_loader.sv
// Directed bench for winograd_tile_loader: SRAM model returns its own address two cycles
// after each enable; tiles, read addresses, cycle timing and done/cfg_err are checked.
module tb_winograd_tile_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [7:0]   size_act;
    logic [15:0]  address_read_base;
    logic [15:0]  address;
    logic         enable_sram;
    logic         wea_sram;
    logic [15:0]  data_in;
    logic [255:0] tile_data;
    logic         tile_valid;
    logic         tile_ready;
    logic         busy;
    logic         done;
    logic         cfg_err;

    always #5 clk = ~clk;

    winograd_tile_loader #(.DATA_W(16), .ADDR_W(16), .SRAM_LAT(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .size_act          (size_act),
        .address_read_base (address_read_base),
        .address           (address),
        .enable_sram       (enable_sram),
        .wea_sram          (wea_sram),
        .data_in           (data_in),
        .tile_data         (tile_data),
        .tile_valid        (tile_valid),
        .tile_ready        (tile_ready),
        .busy              (busy),
        .done              (done),
        .cfg_err           (cfg_err)
    );

    // SRAM model: contents equal the address, two-cycle read latency.
    logic [15:0] s1_a, s2_a;
    logic        s1_v, s2_v;
    always @(posedge clk) begin
        s1_v <= enable_sram;
        s1_a <= address;
        s2_v <= s1_v;
        s2_a <= s1_a;
    end
    assign data_in = s2_v ? s2_a : 16'hBAD0;

    int n_checks = 0;
    int n_fail   = 0;
    int ecnt     = 0;
    int t0       = 0;
    int wea_hits = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        logic [15:0] a;
        int          cyc;
    } rd_t;

    rd_t  rd_q[$];
    int   done_q[$];
    logic derr_q[$];

    // Cycle index = index of the next rising edge relative to the start edge.
    always @(negedge clk) begin
        if (enable_sram) rd_q.push_back('{a: address, cyc: ecnt - t0});
        if (done) begin
            done_q.push_back(ecnt - t0);
            derr_q.push_back(cfg_err);
        end
        if (wea_sram) wea_hits <= wea_hits + 1;
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_addr(input int n, input logic [15:0] base,
                                             input int tr, input int tc, input int k);
        int a;
        a = int'(base) + (tr + k / 4) * n + tc + (k % 4);
        return 16'(a);
    endfunction

    function automatic logic [255:0] exp_tile(input int n, input logic [15:0] base,
                                              input int tr, input int tc);
        logic [255:0] t;
        t = '0;
        for (int k = 0; k < 16; k++) t[16*k +: 16] = exp_addr(n, base, tr, tc, k);
        return t;
    endfunction

    task automatic run_map(input logic [7:0] n, input logic [15:0] base, input int hold_wait,
                           input bit ready_early, input bit poke);
        int ni, side, ntile, tr, tc, ntr, ntc, guard, issue_cyc, x_cyc, vcyc;
        logic [255:0] snap;
        bit poked;
        rd_t r;
        ni    = int'(n);
        side  = (ni - 2) / 2;
        ntile = side * side;
        rd_q.delete();
        done_q.delete();
        derr_q.delete();
        @(negedge clk);
        start = 1'b1;
        size_act = n;
        address_read_base = base;
        t0 = ecnt;
        tile_ready = ready_early;
        @(negedge clk);
        start = 1'b0;
        tr = 0;
        tc = 0;
        issue_cyc = 2;
        x_cyc = 0;
        poked = 1'b0;
        for (int t = 0; t < ntile; t++) begin
            guard = 0;
            while (!tile_valid && guard < 100) begin
                if (poke && !poked && enable_sram) begin
                    start = 1'b1;
                    poked = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                guard++;
            end
            start = 1'b0;
            check_val("tile_valid_rise", tile_valid, 1);
            if (!tile_valid) begin
                tile_ready = 1'b0;
                return;
            end
            vcyc = ecnt - t0;
            check_val("valid_cycle", vcyc, issue_cyc + 18);
            check_val("read_count", rd_q.size(), 16);
            for (int k = 0; k < 16; k++) begin
                if (rd_q.size() > 0) begin
                    r = rd_q.pop_front();
                    check_val("rd_addr", r.a, exp_addr(ni, base, tr, tc, k));
                    check_val("rd_cycle", r.cyc, issue_cyc + k);
                end
            end
            check_val("tile_data", tile_data, exp_tile(ni, base, tr, tc));
            snap = tile_data;
            if (!ready_early) begin
                for (int i = 0; i < hold_wait; i++) begin
                    start = poke && (i == 1);
                    @(negedge clk);
                    check_val("hold_valid", tile_valid, 1);
                    check_val("hold_data", tile_data, snap);
                    check_val("hold_no_read", enable_sram, 0);
                end
                start = 1'b0;
                tile_ready = 1'b1;
            end
            x_cyc = ecnt - t0;
            if (tc == ni - 4) begin
                ntc = 0;
                ntr = tr + 2;
            end else begin
                ntc = tc + 2;
                ntr = tr;
            end
            @(negedge clk);
            if (!ready_early) tile_ready = 1'b0;
            check_val("valid_drop", tile_valid, 0);
            if (t == ntile - 1) begin
                check_val("done_pulse", done, 1);
                check_val("cfg_err_clear", cfg_err, 0);
            end else begin
                check_val("next_issue", enable_sram, 1);
                check_val("next_addr", address, exp_addr(ni, base, ntr, ntc, 0));
            end
            $display("tile %0d at (%0d,%0d) n=%0d base=%04h valid@%0d transfer@%0d",
                     t, tr, tc, ni, base, vcyc, x_cyc);
            tr = ntr;
            tc = ntc;
            issue_cyc = x_cyc + 1;
        end
        start = poke;
        @(negedge clk);
        start = 1'b0;
        tile_ready = 1'b0;
        check_val("idle_after_done", busy, 0);
        check_val("done_once", done_q.size(), 1);
        if (done_q.size() > 0) check_val("done_cycle", done_q[0], x_cyc + 1);
    endtask

    task automatic run_bad(input logic [7:0] n);
        rd_q.delete();
        done_q.delete();
        derr_q.delete();
        @(negedge clk);
        start = 1'b1;
        size_act = n;
        address_read_base = 16'h0010;
        t0 = ecnt;
        @(negedge clk);
        start = 1'b0;
        check_val("bad_busy_c1", busy, 1);
        @(negedge clk);
        check_val("bad_done_c2", done, 1);
        check_val("bad_cfg_err_c2", cfg_err, 1);
        @(negedge clk);
        check_val("bad_idle_c3", busy, 0);
        check_val("bad_done_drop", done, 0);
        check_val("bad_no_reads", rd_q.size(), 0);
        $display("config n=%0d rejected with cfg_err", n);
    endtask

    task automatic run_reset_mid_issue();
        int cnt;
        rd_q.delete();
        @(negedge clk);
        start = 1'b1;
        size_act = 8'd4;
        address_read_base = 16'h0100;
        t0 = ecnt;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int g = 0; g < 40 && cnt < 8; g++) begin
            @(negedge clk);
            if (enable_sram) cnt++;
        end
        check_val("rst_reach_issue8", cnt, 8);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_addr", address, 0);
        check_val("rst_enable", enable_sram, 0);
        check_val("rst_valid", tile_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_tile_data", tile_data, 0);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_val("late_return_dropped", tile_data, 0);
        check_val("rst_stays_idle", busy, 0);
        $display("reset during ISSUE returned to IDLE");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        size_act = '0;
        address_read_base = '0;
        tile_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_addr", address, 0);
        check_val("reset_enable", enable_sram, 0);
        check_val("reset_valid", tile_valid, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_cfg_err", cfg_err, 0);
        check_val("reset_tile_data", tile_data, 0);
        rst_n = 1'b0;

        run_map(8'd4, 16'h0100, 0, 1'b1, 1'b0);
        run_map(8'd6, 16'h0000, 0, 1'b0, 1'b0);
        run_map(8'd6, 16'h0300, 5, 1'b0, 1'b0);
        run_map(8'd6, 16'h0040, 2, 1'b0, 1'b1);
        run_map(8'd4, 16'h0200, 0, 1'b1, 1'b0);
        run_bad(8'd5);
        run_bad(8'd2);
        run_reset_mid_issue();
        run_map(8'd4, 16'hFFFE, 0, 1'b1, 1'b0);
        run_map(8'd8, 16'h1234, 1, 1'b0, 1'b0);

        check_val("wea_never_high", wea_hits, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
